// File: rtl/lut_propagator.sv
// lut_propagator: sweeps stored LUT configs through imply, writing back
// newly implied variable values until a fixpoint or a conflict.

module imply #(
  parameter int LUT_SIZE = 8
) (
  input  logic [2**LUT_SIZE-1:0] tt,
  input  logic [LUT_SIZE:0][1:0] pins,
  output logic [LUT_SIZE:0][1:0] implied,
  output logic                   conflict
);
  localparam int NA = 2**LUT_SIZE;

  logic [LUT_SIZE:0] can0;
  logic [LUT_SIZE:0] can1;
  logic              any;
  logic              ok;
  logic              o;

  // A row is consistent when every known pin agrees with it; a pin is
  // implied when all consistent rows agree on its value.
  always_comb begin
    can0 = '0;
    can1 = '0;
    any  = 1'b0;
    ok   = 1'b0;
    o    = 1'b0;
    for (int a = 0; a < NA; a++) begin
      o  = tt[a];
      ok = 1'b1;
      for (int i = 0; i < LUT_SIZE; i++)
        if (!pins[i][1] && (pins[i][0] != a[i]))
          ok = 1'b0;
      if (!pins[LUT_SIZE][1] && (pins[LUT_SIZE][0] != o))
        ok = 1'b0;
      if (ok) begin
        any = 1'b1;
        for (int i = 0; i < LUT_SIZE; i++)
          if (a[i]) can1[i] = 1'b1;
          else      can0[i] = 1'b1;
        if (o) can1[LUT_SIZE] = 1'b1;
        else   can0[LUT_SIZE] = 1'b1;
      end
    end
    conflict = !any;
    for (int i = 0; i <= LUT_SIZE; i++) begin
      if (can0[i] && !can1[i])
        implied[i] = 2'b00;
      else if (can1[i] && !can0[i])
        implied[i] = 2'b01;
      else
        implied[i] = 2'b11;
    end
  end
endmodule

module lut_propagator #(
  parameter int LUT_SIZE = 8,
  parameter int NUM_LUTS = 16,
  parameter int NUM_VARS = 64,
  parameter int VAR_W    = 6,
  parameter int LUT_W    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_we,
  input  logic [LUT_W-1:0]            cfg_addr,
  input  logic [2**LUT_SIZE-1:0]      cfg_tt,
  input  logic [(LUT_SIZE+1)*VAR_W-1:0] cfg_vars,
  input  logic [LUT_SIZE:0]           cfg_mask,
  input  logic                        assign_valid,
  input  logic [VAR_W-1:0]            assign_var,
  input  logic [1:0]                  assign_val,
  output logic                        assign_ready,
  input  logic                        clear_vars,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        conflict,
  output logic [7:0]                  sweep_count,
  input  logic [VAR_W-1:0]            rd_var,
  output logic [1:0]                  rd_val
);
  localparam int TT_W = 2**LUT_SIZE;
  localparam int NP   = LUT_SIZE + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EVAL  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [NUM_VARS-1:0][1:0] vars;
  logic [TT_W-1:0]          tt_mem   [NUM_LUTS];
  logic [NP*VAR_W-1:0]      vars_mem [NUM_LUTS];
  logic [NP-1:0]            mask_mem [NUM_LUTS];

  logic [LUT_W-1:0]    lut_idx;
  logic                changed;
  logic [TT_W-1:0]     tt_q;
  logic [NP-1:0][1:0]  pins_q;
  logic [NP-1:0][1:0]  imp;
  logic                imp_conflict;

  logic [NP*VAR_W-1:0] cur_vars;
  logic [NP-1:0]       cur_mask;
  logic                lut_en;
  logic                idle;
  logic                accept_start;
  logic                last_lut;
  logic [NP-1:0]       wb;
  logic                wb_any;
  logic                sweep_go;
  logic                finish;
  logic                hit_conflict;

  imply #(
    .LUT_SIZE (LUT_SIZE)
  ) u_imply (
    .tt       (tt_q),
    .pins     (pins_q),
    .implied  (imp),
    .conflict (imp_conflict)
  );

  assign cur_vars     = vars_mem[lut_idx];
  assign cur_mask     = mask_mem[lut_idx];
  assign lut_en       = cur_mask[LUT_SIZE];
  assign idle         = (state == IDLE);
  assign busy         = !idle;
  assign assign_ready = idle;
  // The done cycle is already IDLE, but a start there is still refused.
  assign accept_start = idle && start && !done;
  assign last_lut     = (lut_idx == LUT_W'(NUM_LUTS - 1));
  assign rd_val       = vars[rd_var][1] ? 2'b11 : vars[rd_var];

  always_comb begin
    wb = '0;
    for (int i = 0; i < NP; i++)
      wb[i] = (state == EVAL) && lut_en && !imp_conflict &&
              cur_mask[i] &&
              vars[cur_vars[i*VAR_W +: VAR_W]][1] &&
              !imp[i][1];
  end

  assign wb_any = |wb;

  always_comb begin
    state_nx     = state;
    sweep_go     = 1'b0;
    finish       = 1'b0;
    hit_conflict = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept_start)
          state_nx = FETCH;
      end
      FETCH: begin
        state_nx = EVAL;
      end
      EVAL: begin
        if (lut_en && imp_conflict) begin
          hit_conflict = 1'b1;
          state_nx     = IDLE;
        end else if (!last_lut) begin
          state_nx = FETCH;
        end else if (changed || wb_any) begin
          sweep_go = 1'b1;
          state_nx = FETCH;
        end else begin
          finish   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lut_idx     <= '0;
      changed     <= 1'b0;
      sweep_count <= 8'd0;
      conflict    <= 1'b0;
      done        <= 1'b0;
      tt_q        <= '0;
      pins_q      <= '1;
    end else begin
      state <= state_nx;
      done  <= finish || hit_conflict;
      if (accept_start) begin
        lut_idx     <= '0;
        changed     <= 1'b0;
        sweep_count <= 8'd1;
        conflict    <= 1'b0;
      end
      if (state == FETCH) begin
        tt_q <= tt_mem[lut_idx];
        for (int i = 0; i < NP; i++) begin
          if (!cur_mask[i] || vars[cur_vars[i*VAR_W +: VAR_W]][1])
            pins_q[i] <= 2'b11;
          else
            pins_q[i] <= vars[cur_vars[i*VAR_W +: VAR_W]];
        end
      end
      if ((state == EVAL) && !hit_conflict) begin
        if (wb_any)
          changed <= 1'b1;
        lut_idx <= lut_idx + LUT_W'(1);
        if (sweep_go) begin
          changed <= 1'b0;
          lut_idx <= '0;
          if (sweep_count != 8'hff)
            sweep_count <= sweep_count + 8'd1;
        end
      end
      if (hit_conflict)
        conflict <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vars <= '1;
    end else if (idle && clear_vars) begin
      vars <= '1;
    end else if (idle && assign_valid) begin
      vars[assign_var] <= assign_val;
    end else begin
      // Descending order so the lowest pin wins on a shared index.
      for (int i = NP - 1; i >= 0; i--)
        if (wb[i])
          vars[cur_vars[i*VAR_W +: VAR_W]] <= imp[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_LUTS; j++) begin
        tt_mem[j]   <= '0;
        vars_mem[j] <= '0;
        mask_mem[j] <= '0;
      end
    end else if (idle && cfg_we) begin
      tt_mem[cfg_addr]   <= cfg_tt;
      vars_mem[cfg_addr] <= cfg_vars;
      mask_mem[cfg_addr] <= cfg_mask;
    end
  end
endmodule
